// File: rtl/pick_place_sequencer_if.sv
// Bundle of signals between the pick/place sequencer, the action decoder,
// the path planner and the gripper. The master modport is the sequencer side;
// the slave modport is the surrounding system that drives it.
interface pick_place_sequencer_if #(
    parameter int NODE_W = 5
) ();
    logic              action_valid;
    logic [NODE_W-1:0] pick_node;
    logic [NODE_W-1:0] place_node;
    logic [NODE_W-1:0] current_node;
    logic              nav_done;
    logic              grip_done;
    logic [NODE_W-1:0] nav_target;
    logic              nav_start;
    logic              grip_cmd;
    logic              grip_start;
    logic              task_complete;
    logic              busy;
    logic              reject;
    logic              error;
    logic [7:0]        done_count;

    modport master (
        input  action_valid, pick_node, place_node, current_node, nav_done, grip_done,
        output nav_target, nav_start, grip_cmd, grip_start, task_complete, busy,
               reject, error, done_count
    );

    modport slave (
        output action_valid, pick_node, place_node, current_node, nav_done, grip_done,
        input  nav_target, nav_start, grip_cmd, grip_start, task_complete, busy,
               reject, error, done_count
    );
endinterface

// File: rtl/pick_place_sequencer.sv
// Pick-and-place sequencer: latches one decoded action, drives the bot to the
// pick node, closes the gripper, drives to the place node, opens the gripper
// and reports completion. Invalid (zero) nodes are rejected without motion.
// Optional feature macro SEQ_WATCHDOG_EN: adds a navigation watchdog that
// traps into a sticky FAULT state after TIMEOUT_CYCLES waiting cycles.
module pick_place_sequencer #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000,
    parameter int          NODE_W         = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pick_place_sequencer_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, NAV_PICK, WAIT_PICK, GRIP_PICK, WAIT_GPICK,
        NAV_PLACE, WAIT_PLACE, GRIP_PLACE, WAIT_GPLACE,
        DONE, RELEASE, FAULT
    } state_t;

    state_t            state_reg, state_next;
    logic [NODE_W-1:0] pick_reg, place_reg;
    logic              rejected_reg;
    logic [7:0]        done_count_reg;
    logic [NODE_W-1:0] nav_target_next;
    logic              nav_start_next, grip_cmd_next, grip_start_next;
    logic              task_complete_next, reject_next;
    logic              timeout_hit;

`ifdef SEQ_WATCHDOG_EN
    logic [23:0] wd_cnt_reg;

    // Watchdog: zero outside the navigation waits, counts every waiting cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_reg <= '0;
        end else if (state_reg == WAIT_PICK || state_reg == WAIT_PLACE) begin
            wd_cnt_reg <= wd_cnt_reg + 24'd1;
        end else begin
            wd_cnt_reg <= '0;
        end
    end

    assign timeout_hit = (wd_cnt_reg == TIMEOUT_CYCLES - 24'd1);
    assign bus.error   = (state_reg == FAULT);
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
    assign bus.error      = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Action latch and completed-action counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pick_reg       <= '0;
            place_reg      <= '0;
            rejected_reg   <= 1'b0;
            done_count_reg <= 8'd0;
        end else begin
            if (state_reg == IDLE && bus.action_valid) begin
                pick_reg     <= bus.pick_node;
                place_reg    <= bus.place_node;
                rejected_reg <= (bus.pick_node == '0) || (bus.place_node == '0);
            end
            if (state_reg == DONE && !rejected_reg) begin
                done_count_reg <= done_count_reg + 8'd1;
            end
        end
    end

    // Next-state and command outputs; every pulse lives in a one-cycle state.
    always_comb begin
        state_next         = state_reg;
        nav_target_next    = '0;
        nav_start_next     = 1'b0;
        grip_cmd_next      = 1'b0;
        grip_start_next    = 1'b0;
        task_complete_next = 1'b0;
        reject_next        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.action_valid) begin
                    if (bus.pick_node == '0 || bus.place_node == '0) state_next = DONE;
                    else                                               state_next = NAV_PICK;
                end
            end
            NAV_PICK: begin
                nav_target_next = pick_reg;
                if (bus.current_node == pick_reg) begin
                    state_next = GRIP_PICK;
                end else begin
                    nav_start_next = 1'b1;
                    state_next     = WAIT_PICK;
                end
            end
            WAIT_PICK: begin
                nav_target_next = pick_reg;
                if (bus.nav_done)  state_next = GRIP_PICK;
                else if (timeout_hit) state_next = FAULT;
            end
            GRIP_PICK: begin
                nav_target_next = pick_reg;
                grip_cmd_next   = 1'b1;
                grip_start_next = 1'b1;
                state_next      = WAIT_GPICK;
            end
            WAIT_GPICK: begin
                nav_target_next = pick_reg;
                grip_cmd_next   = 1'b1;
                if (bus.grip_done) state_next = NAV_PLACE;
            end
            NAV_PLACE: begin
                nav_target_next = place_reg;
                if (bus.current_node == place_reg) begin
                    state_next = GRIP_PLACE;
                end else begin
                    nav_start_next = 1'b1;
                    state_next     = WAIT_PLACE;
                end
            end
            WAIT_PLACE: begin
                nav_target_next = place_reg;
                if (bus.nav_done)  state_next = GRIP_PLACE;
                else if (timeout_hit) state_next = FAULT;
            end
            GRIP_PLACE: begin
                nav_target_next = place_reg;
                grip_start_next = 1'b1;
                state_next      = WAIT_GPLACE;
            end
            WAIT_GPLACE: begin
                nav_target_next = place_reg;
                if (bus.grip_done) state_next = DONE;
            end
            DONE: begin
                task_complete_next = 1'b1;
                reject_next        = rejected_reg;
                state_next         = RELEASE;
            end
            RELEASE: begin
                if (!bus.action_valid) state_next = IDLE;
            end
            FAULT: begin
                state_next = FAULT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.nav_target    = nav_target_next;
    assign bus.nav_start     = nav_start_next;
    assign bus.grip_cmd      = grip_cmd_next;
    assign bus.grip_start    = grip_start_next;
    assign bus.task_complete = task_complete_next;
    assign bus.reject        = reject_next;
    assign bus.busy          = (state_reg != IDLE);
    assign bus.done_count    = done_count_reg;
endmodule

// File: tb/tb_pick_place_sequencer.sv
// Self-checking bench for pick_place_sequencer: a planner/gripper responder,
// an event monitor, and a reference model that predicts the event list of
// every action directly from the pick/place/current node values.
module tb_pick_place_sequencer;
    localparam int NODE_W = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pick_place_sequencer_if #(.NODE_W(NODE_W)) bus ();

    pick_place_sequencer #(.TIMEOUT_CYCLES(24'd100), .NODE_W(NODE_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int passes = 0;
    int obs_q[$];
    int exp_q[$];
    int model_count = 0;
    int back2back = 0;
    int stray_reject = 0;

    // Bot position: base_node is set per action, the responder overrides it
    // once it has moved the bot during that same action.
    int              action_id = 0;
    int              moved_gen = -1;
    logic [NODE_W-1:0] base_node = '0;
    logic [NODE_W-1:0] moved_node = '0;
    assign bus.current_node = (moved_gen == action_id) ? moved_node : base_node;

    int nav_dly = 0;
    int grip_dly = 0;
    bit nav_hold = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Planner and gripper responder.
    initial begin
        int nt = 0;
        int gt = 0;
        logic [NODE_W-1:0] pend = '0;
        bus.nav_done  = 1'b0;
        bus.grip_done = 1'b0;
        forever begin
            @(negedge clk);
            bus.nav_done  = 1'b0;
            bus.grip_done = 1'b0;
            if (!rst_n) begin
                nt = 0;
                gt = 0;
            end
            if (nt > 0) begin
                nt--;
                if (nt == 0) begin
                    bus.nav_done = 1'b1;
                    moved_node   = pend;
                    moved_gen    = action_id;
                end
            end
            if (gt > 0) begin
                gt--;
                if (gt == 0) bus.grip_done = 1'b1;
            end
            if (bus.nav_start && !nav_hold) begin
                pend = bus.nav_target;
                nt   = (nav_dly != 0) ? nav_dly : int'($urandom_range(1, 6));
            end
            if (bus.grip_start) gt = (grip_dly != 0) ? grip_dly : int'($urandom_range(1, 4));
        end
    end

    // Event monitor: type<<12 | flag<<8 | node.
    initial begin
        logic ns_p = 1'b0, gs_p = 1'b0, tc_p = 1'b0, rj_p = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.nav_start)     obs_q.push_back((1 << 12) | int'(bus.nav_target));
            if (bus.grip_start)    obs_q.push_back((2 << 12) | (int'(bus.grip_cmd) << 8) | int'(bus.nav_target));
            if (bus.task_complete) obs_q.push_back((3 << 12) | (int'(bus.reject) << 8));
            if (bus.reject && !bus.task_complete) stray_reject++;
            if ((bus.nav_start && ns_p) || (bus.grip_start && gs_p) ||
                (bus.task_complete && tc_p) || (bus.reject && rj_p)) back2back++;
            ns_p = bus.nav_start;
            gs_p = bus.grip_start;
            tc_p = bus.task_complete;
            rj_p = bus.reject;
        end
    end

    // Predict, run and compare one action.
    task automatic run_action(input logic [NODE_W-1:0] p, input logic [NODE_W-1:0] q,
                              input logic [NODE_W-1:0] c, input int hold, input bit mutate);
        int n;
        int busy_n;
        int nobs;
        bit ok;
        ok = (p != 0) && (q != 0);
        action_id++;
        base_node = c;
        if (!ok) begin
            exp_q.push_back((3 << 12) | (1 << 8));
        end else begin
            if (c != p) exp_q.push_back((1 << 12) | int'(p));
            exp_q.push_back((2 << 12) | (1 << 8) | int'(p));
            if (p != q) exp_q.push_back((1 << 12) | int'(q));
            exp_q.push_back((2 << 12) | int'(q));
            exp_q.push_back(3 << 12);
            model_count = (model_count + 1) % 256;
        end
        @(negedge clk);
        bus.action_valid = 1'b1;
        bus.pick_node    = p;
        bus.place_node   = q;
        n = 0;
        busy_n = 0;
        do begin
            @(negedge clk);
            n++;
            if (bus.busy) busy_n++;
            if (mutate && n == 1) begin
                bus.pick_node  = NODE_W'($urandom);
                bus.place_node = NODE_W'($urandom);
            end
        end while (!bus.task_complete && n < 500);
        chk("tc_timeout", 32'(n < 500), 1);
        repeat (hold) begin
            @(negedge clk);
            if (bus.busy) busy_n++;
        end
        bus.action_valid = 1'b0;
        n = 0;
        while (bus.busy && n < 20) begin
            @(negedge clk);
            n++;
            if (bus.busy) busy_n++;
        end
        chk("release_timeout", 32'(bus.busy), 0);
        if (!ok && hold == 0) chk("reject_busy_cycles", busy_n, 2);
        nobs = obs_q.size();
        chk("event_count", nobs, exp_q.size());
        for (int i = 0; i < nobs && i < exp_q.size(); i++) chk("event", obs_q[i], exp_q[i]);
        chk("done_count", 32'(bus.done_count), model_count);
        $display("action %0d pick=%0d place=%0d cur=%0d hold=%0d events=%0d done_count=%0d",
                 action_id, p, q, c, hold, nobs, bus.done_count);
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int n;
        int tc_seen;
        bus.action_valid = 1'b0;
        bus.pick_node    = '0;
        bus.place_node   = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_nav_target", 32'(bus.nav_target), 0);
        chk("rst_grip_cmd", 32'(bus.grip_cmd), 0);
        chk("rst_done_count", 32'(bus.done_count), 0);
        chk("rst_error", 32'(bus.error), 0);
        chk("rst_task_complete", 32'(bus.task_complete), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        obs_q.delete();

        // Directed scenarios.
        nav_dly = 5;
        grip_dly = 3;
        run_action(5'd27, 5'd9, 5'd0, 0, 1'b0);
        run_action(5'd5, 5'd27, 5'd5, 0, 1'b0);
        run_action(5'd0, 5'd9, 5'd3, 0, 1'b0);
        run_action(5'd4, 5'd0, 5'd3, 1, 1'b0);
        run_action(5'd12, 5'd12, 5'd1, 2, 1'b1);
        run_action(5'd7, 5'd3, 5'd2, 2, 1'b0);

        // Randomized actions.
        nav_dly = 0;
        grip_dly = 0;
        for (int k = 0; k < 30; k++) begin
            logic [NODE_W-1:0] p, q, c;
            p = ($urandom_range(0, 7) == 0) ? '0 : NODE_W'($urandom);
            q = ($urandom_range(0, 7) == 0) ? '0 : NODE_W'($urandom);
            case ($urandom_range(0, 2))
                0:       c = p;
                1:       c = q;
                default: c = NODE_W'($urandom);
            endcase
            run_action(p, q, c, int'($urandom_range(0, 2)), 1'($urandom));
        end

        // Reset during WAIT_GPLACE abandons the action.
        grip_dly = 3;
        nav_dly = 2;
        action_id++;
        base_node = 5'd0;
        @(negedge clk);
        bus.action_valid = 1'b1;
        bus.pick_node    = 5'd3;
        bus.place_node   = 5'd7;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.grip_start && !bus.grip_cmd) && n < 200);
        chk("gplace_timeout", 32'(n < 200), 1);
        @(negedge clk);
        chk("pre_reset_busy", 32'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_nav_target", 32'(bus.nav_target), 0);
        chk("mid_rst_grip_cmd", 32'(bus.grip_cmd), 0);
        chk("mid_rst_done_count", 32'(bus.done_count), 0);
        chk("mid_rst_pulses", {28'd0, bus.nav_start, bus.grip_start, bus.task_complete, bus.reject}, 0);
        bus.action_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        tc_seen = 0;
        foreach (obs_q[i]) if ((obs_q[i] >> 12) == 3) tc_seen++;
        chk("mid_rst_no_tc", tc_seen, 0);
        chk("post_rst_busy", 32'(bus.busy), 0);
        obs_q.delete();
        model_count = 0;
        run_action(5'd8, 5'd2, 5'd8, 0, 1'b0);

`ifdef SEQ_WATCHDOG_EN
        // Watchdog: nav_done withheld, FAULT after 100 waiting cycles.
        nav_hold = 1'b1;
        action_id++;
        base_node = 5'd0;
        @(negedge clk);
        bus.action_valid = 1'b1;
        bus.pick_node    = 5'd3;
        bus.place_node   = 5'd7;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.nav_start && n < 20);
        chk("wd_nav_start_timeout", 32'(n < 20), 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.error && n < 300);
        chk("wd_fault_cycle", n, 101);
        chk("wd_busy", 32'(bus.busy), 1);
        repeat (3) @(negedge clk);
        chk("wd_sticky", 32'(bus.error), 1);
        tc_seen = 0;
        foreach (obs_q[i]) if ((obs_q[i] >> 12) == 3) tc_seen++;
        chk("wd_no_tc", tc_seen, 0);
        bus.action_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("wd_rst_error", 32'(bus.error), 0);
        @(negedge clk);
        rst_n = 1'b1;
        nav_hold = 1'b0;
`else
        chk("error_const", 32'(bus.error), 0);
`endif

        chk("pulse_back2back", back2back, 0);
        chk("stray_reject", stray_reject, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
